mips_io_resp: RTL
=================

Name: mips_io_resp

Overview:
- Memory-mapped I/O responder on the processor memory bus (memread, memwrite, adr, writedata → read data).
- Sits beside exmem and claims the address window IOBASE..IOBASE+15.
- Provides:
  - a transmit FIFO drained by an external valid/ready consumer
  - a compare-wrap timer with sticky flag
  - an LED register
- The top level selects iodata over memdata whenever iosel is high.

Parameters:
- WIDTH, 8, data and address width.
- IOBASE, 8'hF0, base of the I/O window. Decode compares adr[WIDTH-1:4] == IOBASE[WIDTH-1:4].
- FIFO_DEPTH, 4, transmit FIFO entries. Must be a power of two.
- PTRBITS, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- memread  in  1  processor read strobe.
- memwrite  in  1  processor write strobe.
- adr  in  WIDTH  processor address.
- writedata  in  WIDTH  processor write data.
- iodata  out  WIDTH  registered read data; valid the cycle after the read.
- iosel  out  1  registered; high the cycle after a read that hit the window.
- out_data  out  WIDTH  FIFO head entry.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- leds  out  WIDTH  LED register contents.

Behaviour:
- Hit: hit = adr[WIDTH-1:4] == IOBASE[WIDTH-1:4] (combinational). Register offset is adr[3:0].
- Register map:
  - 0 TXDATA: write pushes writedata into FIFO; read returns 0.
  - 1 STATUS: read {0…, ovf[3], full[2], empty[1], tflag[0]}. Write is W1C: bit3 clears ovf, bit0 clears tflag; other bits ignored.
  - 2 TCOUNT: read/write timer count.
  - 3 TCMP: read/write compare value.
  - 4 LED: read/write; drives leds.
  - 5–15: reads return 0, writes are ignored.
- Read latency is 1 cycle, matching exmem:
  - On the edge where memread & hit: iodata <= selected register (pre-edge value), iosel <= 1.
  - On the edge where memread & !hit: iosel <= 0 and iodata holds its value.
  - With no memread, iosel <= 0.
- If memread and memwrite are both high, both are honoured; the read returns the pre-write value.
- Writes take effect at the edge where memwrite & hit.
- FIFO:
  - Circular buffer with rd/wr pointers of PTRBITS bits and a PTRBITS+1 count.
  - push = memwrite & hit & offset 0. pop = out_valid & out_ready.
  - Push while full (judged on the pre-edge count) is dropped and sets ovf, even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: count is unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is the head entry and is undefined when empty; the bench must not check it then.
- Timer:
  - When TCMP == 0, TCOUNT holds.
  - Otherwise, each cycle: if TCOUNT == TCMP then TCOUNT <= 0 and tflag <= 1; else TCOUNT <= TCOUNT + 1.
  - A CPU write to TCOUNT overrides that cycle's increment/wrap.
  - A write to TCMP takes effect for the next cycle's compare.
- Sticky flag priority: when a set (tflag match or ovf event) and a W1C clear of the same bit occur in the same cycle, set wins.
- Reset: iodata=0, iosel=0, leds=0, out_valid=0 (FIFO empty, pointers 0), TCOUNT=0, TCMP=0, tflag=0, ovf=0.
  - STATUS reads 8'h02 after reset.
  - Reset mid-operation discards FIFO contents immediately (asynchronous).

Decomposition:
- Shared package mips_io_pkg holds:
  - register offset constants: OFF_TXDATA=0, OFF_STATUS=1, OFF_TCOUNT=2, OFF_TCMP=3, OFF_LED=4
  - STATUS bit positions: ST_TFLAG=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3
- One natural sub-module: io_fifo (parameterised WIDTH/PTRBITS; push, pop, din, dout, full, empty).
- Decode, timer and register read mux stay in mips_io_resp.

Test Plan:
- Reset, then read STATUS (adr=F1): iosel=1 with iodata=8'h02 one cycle later; leds=0; out_valid=0.
- Write 8'hA5 to F4 and read it back: leds=A5 and iodata=A5. Read adr=8'h10: iosel=0.
- Hold out_ready=0 and push 11,22,33,44,55: STATUS=8'h0C (ovf, full). Then set out_ready=1: consumer receives 11,22,33,44 in order, and STATUS=8'h0A after draining.
- FIFO boundaries, each a separate case:
  - With the FIFO full and out_ready=1, push 66: 66 is dropped and ovf is set.
  - With one entry and out_ready=1, push 77: count stays 1 and the next head is 77.
- TCMP=3: TCOUNT sequence is 0,1,2,3,0 and tflag sets on the wrap. A W1C write of 01 to STATUS clears tflag; a W1C issued in the same cycle as a wrap leaves tflag=1.
- Assert reset mid-drain with 3 entries queued: out_valid drops immediately (asynchronous), and STATUS reads 02 after release.

Source files
------------

// File: rtl/mips_io_pkg.sv
// Shared constants for the memory-mapped I/O responder: register offsets and STATUS bit positions.
package mips_io_pkg;

   // Register offsets within the 16-byte I/O window
   localparam logic [3:0] OFF_TXDATA = 4'd0;
   localparam logic [3:0] OFF_STATUS = 4'd1;
   localparam logic [3:0] OFF_TCOUNT = 4'd2;
   localparam logic [3:0] OFF_TCMP   = 4'd3;
   localparam logic [3:0] OFF_LED    = 4'd4;

   // STATUS register bit positions
   localparam int unsigned ST_TFLAG = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_FULL  = 2;
   localparam int unsigned ST_OVF   = 3;

endpackage

// File: rtl/mips_io_resp_io_fifo.sv
// Circular transmit FIFO; a push while full is dropped, a pop while empty is ignored.
module io_fifo #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PTRBITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [PTRBITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRBITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTRBITS:0]   count_q, count_d;
   logic               do_push, do_pop;

   assign full    = (count_q == DEPTH[PTRBITS:0]);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally at PTRBITS bits
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   // Pointer/count state, cleared asynchronously so contents vanish at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mips_io_resp.sv
// Memory-mapped I/O responder: TX FIFO, compare-wrap timer with sticky flag, LED register.
module mips_io_resp
   import mips_io_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] IOBASE     = 8'hF0,
   parameter int unsigned      FIFO_DEPTH = 4,
   parameter int unsigned      PTRBITS    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memread,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] iodata,
   output logic             iosel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] leds
);

   logic             hit, wr_en;
   logic [3:0]       off;
   logic             fifo_full, fifo_empty, push, pop;
   logic             tmatch;
   logic [WIDTH-1:0] status, rdata;

   logic [WIDTH-1:0] iodata_q, iodata_d;
   logic             iosel_q, iosel_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic [WIDTH-1:0] tcount_q, tcount_d;
   logic [WIDTH-1:0] tcmp_q, tcmp_d;
   logic             tflag_q, tflag_d;
   logic             ovf_q, ovf_d;

   assign hit   = (adr[WIDTH-1:4] == IOBASE[WIDTH-1:4]);
   assign off   = adr[3:0];
   assign wr_en = memwrite & hit;
   assign push  = wr_en & (off == OFF_TXDATA);
   assign pop   = out_valid & out_ready;

   io_fifo #(
      .WIDTH   (WIDTH),
      .DEPTH   (FIFO_DEPTH),
      .PTRBITS (PTRBITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (writedata),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = ~fifo_empty;

   // STATUS image and read mux over pre-edge register values
   always_comb begin
      status           = '0;
      status[ST_TFLAG] = tflag_q;
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_OVF]   = ovf_q;
      case (off)
         OFF_STATUS: rdata = status;
         OFF_TCOUNT: rdata = tcount_q;
         OFF_TCMP:   rdata = tcmp_q;
         OFF_LED:    rdata = leds_q;
         default:    rdata = '0;
      endcase
   end

   // Register writes, timer step and sticky flags (a set beats a same-cycle W1C)
   always_comb begin
      iodata_d = iodata_q;
      iosel_d  = 1'b0;
      if (memread && hit) begin
         iodata_d = rdata;
         iosel_d  = 1'b1;
      end

      leds_d = leds_q;
      tcmp_d = tcmp_q;
      if (wr_en && off == OFF_LED)  leds_d = writedata;
      if (wr_en && off == OFF_TCMP) tcmp_d = writedata;

      tmatch   = (tcmp_q != '0) && (tcount_q == tcmp_q);
      tcount_d = tcount_q;
      if (tcmp_q != '0) tcount_d = tmatch ? '0 : tcount_q + WIDTH'(1);
      if (wr_en && off == OFF_TCOUNT) tcount_d = writedata;

      tflag_d = tflag_q;
      ovf_d   = ovf_q;
      if (wr_en && off == OFF_STATUS) begin
         if (writedata[ST_TFLAG]) tflag_d = 1'b0;
         if (writedata[ST_OVF])   ovf_d   = 1'b0;
      end
      if (tmatch)           tflag_d = 1'b1;
      if (push && fifo_full) ovf_d  = 1'b1;
   end

   // Architectural state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iodata_q <= '0;
         iosel_q  <= 1'b0;
         leds_q   <= '0;
         tcount_q <= '0;
         tcmp_q   <= '0;
         tflag_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         iodata_q <= iodata_d;
         iosel_q  <= iosel_d;
         leds_q   <= leds_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         tflag_q  <= tflag_d;
         ovf_q    <= ovf_d;
      end
   end

   assign iodata = iodata_q;
   assign iosel  = iosel_q;
   assign leds   = leds_q;

endmodule
